mips_writeback: RTL and testbench
=================================

Name: mips_writeback

Overview:
- Writeback stage of the MIPS pipeline. It accepts retiring instructions from the MEM stage through a valid/ready handshake.
- On accept it selects the result (ALU result, extended load data, or link address) and holds it in a 2-entry buffer.
- It drives the register file write port (regWrite, writeRegister, writeData) in order, one entry per cycle.
- It answers forwarding lookups for the rs/rt operands against results that are buffered but not yet written.

Parameters:
- DEPTH, 2, buffer entries. Only the value 2 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  MEM stage presents an instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- in_reg_write  input  1  instruction writes a GPR.
- in_rd  input  5  destination register.
- in_wb_sel  input  2  result source: 0 = ALU, 1 = MEM, 2 = LINK; 3 is treated as ALU.
- in_alu_result  input  32  ALU result.
- in_mem_data  input  32  raw load word.
- in_pc_plus4  input  32  link address is in_pc_plus4 + 4.
- in_load_size  input  2  0 = word, 1 = half, 2 = byte; 3 is treated as word.
- in_load_signed  input  1  sign-extend sub-word loads.
- in_addr_lo  input  2  low bits of the load address.
- wb_hold  input  1  freezes draining (debug/stall).
- regWrite  output  1  register file write enable.
- writeRegister  output  5  register file write address.
- writeData  output  32  register file write data.
- fwd_rs, fwd_rt  input  5 each  operand lookup addresses.
- fwd_rs_hit, fwd_rt_hit  output  1 each  a buffered entry matches.
- fwd_rs_data, fwd_rt_data  output  32 each  matching data (0 when no hit).
- retired  output  CNT_W  count of drained entries.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - count = 0, head pointer = 0, retired = 0.
  - Buffered entries are discarded, including during reset mid-operation.
  - While count = 0: regWrite = 0, writeRegister = 0, writeData = 0, and fwd_*_hit = 0.
- Accept:
  - push = in_valid && in_ready.
  - in_ready = (count < 2). It is registered-state only, so a same-cycle pop does not raise it.
  - Each entry stores {we, rd, data}. The data is computed at accept time.
  - we = in_reg_write && (in_rd != 0). Writes to $0 are never issued.
- Result select:
  - ALU: data = in_alu_result.
  - LINK: data = in_pc_plus4 + 4, wrapping modulo 2^32.
  - MEM, word: data = in_mem_data.
  - MEM, half: lane = in_mem_data[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - MEM, byte: lane = in_mem_data[8*addr_lo +: 8]. Lanes are little-endian.
  - Sub-word lanes are zero-extended, or sign-extended when in_load_signed = 1.
- Drain:
  - pop = (count > 0) && !wb_hold.
  - regWrite = pop && head.we; writeRegister = head.rd; writeData = head.data. These are combinational from registered state, so they are stable for the whole cycle.
  - The register file commits at negedge, so the value is readable in the second half of the drain cycle.
  - On a pop, head advances at posedge and retired increments (including entries with we = 0), wrapping at 2^CNT_W.
- Latency: an instruction accepted at posedge N into an empty buffer appears on the write port during cycle N+1 if wb_hold = 0.
- Simultaneous push and pop:
  - count = 1: count stays 1, and the new entry becomes head after the pop.
  - count = 0: a push with no pop; the entry is not bypassed to the write port in the same cycle.
- wb_hold:
  - regWrite = 0 and nothing drains.
  - Pushes continue until count = 2, then in_ready = 0.
- Forwarding:
  - Compare fwd_rs and fwd_rt against every valid entry with we = 1.
  - The youngest match wins. Address 0 never hits.
  - A match includes the head during its drain cycle.
- Order: drains follow strict FIFO order; entries are never reordered or dropped.

Decomposition:
- Package mips_wb_pkg holds:
  - WB_SEL_ALU/MEM/LINK constants;
  - LOAD_WORD/HALF/BYTE constants;
  - the wb_entry_t struct {we, rd[4:0], data[31:0]}.
- Sub-module load_extend (combinational) computes lane select and sign/zero extension from mem_data, size, signed and addr_lo. It is reused later by the load/store unit.

Test Plan:
- Reset mid-fill: push 2 entries, assert rst_n = 0 for 1 cycle, then check count = 0, regWrite = 0, retired = 0 and in_ready = 1, and that no write occurs afterwards.
- Result select:
  - ALU push rd = 5, data 0xDEADBEEF: next cycle regWrite = 1, writeRegister = 5, writeData = 0xDEADBEEF.
  - LINK with pc_plus4 = 0xFFFFFFFC: writeData = 0x00000000.
- Load extend with mem_data = 0x8077F001:
  - signed byte, addr_lo = 3: writeData = 0xFFFFFF80;
  - unsigned half, addr_lo = 2: writeData = 0x00008077;
  - signed byte, addr_lo = 0: writeData = 0x00000001.
- $0 suppression: push rd = 0 with reg_write = 1. On drain, regWrite = 0, retired increments by 1, and fwd_rs = 0 gives hit = 0.
- Backpressure:
  - wb_hold = 1, push 3 back-to-back: the 3rd is refused (in_ready = 0 after 2).
  - Release hold: writes for rd = 1 then rd = 2 occur on consecutive cycles, in order, and retired = 2.
- Forwarding priority: with hold = 1, buffer rd = 7 = 0x11 (older) and rd = 7 = 0x22 (younger). fwd_rs = 7 gives hit = 1, data = 0x22; fwd_rt = 8 gives hit = 0, data = 0.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared writeback types and encodings: result-source and load-size codes,
// the buffered entry layout and the forwarding lookup helper.
package mips_wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] LOAD_WORD = 2'd0;
    localparam logic [1:0] LOAD_HALF = 2'd1;
    localparam logic [1:0] LOAD_BYTE = 2'd2;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Returns {hit, data}; the younger entry overrides the older one, $0 never hits.
    function automatic logic [32:0] fwd_lookup(
        input logic [4:0] addr,
        input wb_entry_t  old_e,
        input logic       old_v,
        input wb_entry_t  yng_e,
        input logic       yng_v
    );
        logic [32:0] res;
        res = '0;
        if (addr != 5'd0) begin
            if (old_v && old_e.we && (old_e.rd == addr)) res = {1'b1, old_e.data};
            if (yng_v && yng_e.we && (yng_e.rd == addr)) res = {1'b1, yng_e.data};
        end
        return res;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension, little-endian lanes.
// Purely combinational; no latency, no flow control.
module load_extend
    import mips_wb_pkg::*;
(
    input  logic [31:0] i_mem_data,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Halfword lane only looks at addr_lo[1]; misaligned low bit is ignored.
    assign w_half = i_addr_lo[1] ? i_mem_data[31:16] : i_mem_data[15:0];

    always_comb begin
        w_byte = i_mem_data[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_mem_data[15:8];
            2'd2:    w_byte = i_mem_data[23:16];
            2'd3:    w_byte = i_mem_data[31:24];
            default: w_byte = i_mem_data[7:0];
        endcase
    end

    always_comb begin
        o_data = i_mem_data;
        case (i_size)
            LOAD_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            LOAD_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            default:   o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/mips_writeback.sv
// MIPS writeback: 2-entry result buffer feeding the register file write port in order.
// Accept-to-write latency 1 cycle; in_ready drops when 2 entries are held (wb_hold freezes draining).
module mips_writeback
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [31:0]      in_pc_plus4,
    input  logic [1:0]       in_load_size,
    input  logic             in_load_signed,
    input  logic [1:0]       in_addr_lo,
    input  logic             wb_hold,
    output logic             regWrite,
    output logic [4:0]       writeRegister,
    output logic [31:0]      writeData,
    input  logic [4:0]       fwd_rs,
    input  logic [4:0]       fwd_rt,
    output logic             fwd_rs_hit,
    output logic             fwd_rt_hit,
    output logic [31:0]      fwd_rs_data,
    output logic [31:0]      fwd_rt_data,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] DEPTH_C = DEPTH[1:0];

    wb_entry_t        r_buf [2];
    logic             r_head;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_retired;

    logic        w_push;
    logic        w_pop;
    logic        w_tail;
    logic        w_nonempty;
    logic        w_full;
    logic [31:0] w_ld_data;
    logic [31:0] w_result;
    wb_entry_t   w_new;
    wb_entry_t   w_head;
    wb_entry_t   w_young;
    logic [32:0] w_rs_lk;
    logic [32:0] w_rt_lk;

    load_extend u_load_extend (
        .i_mem_data (in_mem_data),
        .i_size     (in_load_size),
        .i_signed   (in_load_signed),
        .i_addr_lo  (in_addr_lo),
        .o_data     (w_ld_data)
    );

    always_comb begin
        w_result = in_alu_result;
        case (in_wb_sel)
            WB_SEL_ALU:  w_result = in_alu_result;
            WB_SEL_MEM:  w_result = w_ld_data;
            WB_SEL_LINK: w_result = in_pc_plus4 + 32'd4;
            default:     w_result = in_alu_result;
        endcase
    end

    assign w_new.we   = in_reg_write && (in_rd != 5'd0);
    assign w_new.rd   = in_rd;
    assign w_new.data = w_result;

    // in_ready looks only at registered occupancy, so a same-cycle pop never raises it.
    assign in_ready   = (r_count < DEPTH_C);
    assign w_nonempty = (r_count != 2'd0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = w_nonempty && !wb_hold;
    assign w_tail     = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_retired <= '0;
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
        end else begin
            if (w_push) r_buf[w_tail] <= w_new;
            if (w_pop) begin
                r_head    <= ~r_head;
                r_retired <= r_retired + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = r_buf[r_head];
    assign w_young = r_buf[~r_head];

    assign regWrite      = w_pop && w_head.we;
    assign writeRegister = w_nonempty ? w_head.rd   : 5'd0;
    assign writeData     = w_nonempty ? w_head.data : 32'd0;
    assign retired       = r_retired;

    // The second slot only holds a live entry when full, and it is always the younger one.
    assign w_rs_lk = fwd_lookup(fwd_rs, w_head, w_nonempty, w_young, w_full);
    assign w_rt_lk = fwd_lookup(fwd_rt, w_head, w_nonempty, w_young, w_full);

    assign fwd_rs_hit  = w_rs_lk[32];
    assign fwd_rs_data = w_rs_lk[31:0];
    assign fwd_rt_hit  = w_rt_lk[32];
    assign fwd_rt_data = w_rt_lk[31:0];

endmodule

// File: tb/tb_mips_writeback.sv
// Bench for mips_writeback: table of single-instruction vectors plus
// hand-written sequences for hold/backpressure, forwarding priority and reset.
module tb_mips_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus4;
    logic [1:0]  in_load_size;
    logic        in_load_signed;
    logic [1:0]  in_addr_lo;
    logic        wb_hold;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [4:0]  fwd_rs;
    logic [4:0]  fwd_rt;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_rs_data;
    logic [31:0] fwd_rt_data;
    logic [31:0] retired;

    int n_checks;
    int n_fail;
    int exp_retired;

    mips_writeback #(.DEPTH(2), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_rd          (in_rd),
        .in_wb_sel      (in_wb_sel),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .in_pc_plus4    (in_pc_plus4),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .in_addr_lo     (in_addr_lo),
        .wb_hold        (wb_hold),
        .regWrite       (regWrite),
        .writeRegister  (writeRegister),
        .writeData      (writeData),
        .fwd_rs         (fwd_rs),
        .fwd_rt         (fwd_rt),
        .fwd_rs_hit     (fwd_rs_hit),
        .fwd_rt_hit     (fwd_rt_hit),
        .fwd_rs_data    (fwd_rs_data),
        .fwd_rt_data    (fwd_rt_data),
        .retired        (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr_lo;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                          input logic [1:0] size, input logic sgn, input logic [1:0] lo);
        in_reg_write   = rw;
        in_rd          = rd;
        in_wb_sel      = sel;
        in_alu_result  = alu;
        in_mem_data    = mem;
        in_pc_plus4    = pc4;
        in_load_size   = size;
        in_load_signed = sgn;
        in_addr_lo     = lo;
    endtask

    task automatic push_alu(input logic [4:0] rd, input logic [31:0] val);
        set_in(1'b1, rd, 2'd0, val, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        in_valid = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_retired = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        wb_hold     = 1'b0;
        fwd_rs      = 5'd0;
        fwd_rt      = 5'd0;
        set_in(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);

        //             rw    rd     sel    alu           mem           pc4           sz     sgn   lo     we    data
        vecs[0]  = '{1'b1, 5'd5,  2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        2'd0, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd31, 2'd2, 32'h12345678, 32'h0,        32'hFFFFFFFC, 2'd0, 1'b0, 2'd0, 1'b1, 32'h00000000};
        vecs[2]  = '{1'b1, 5'd3,  2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd2, 1'b1, 2'd3, 1'b1, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 5'd4,  2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd1, 1'b0, 2'd2, 1'b1, 32'h00008077};
        vecs[4]  = '{1'b1, 5'd6,  2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd2, 1'b1, 2'd0, 1'b1, 32'h00000001};
        vecs[5]  = '{1'b1, 5'd8,  2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd1, 1'b1, 2'd0, 1'b1, 32'hFFFFF001};
        vecs[6]  = '{1'b1, 5'd9,  2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd2, 1'b0, 2'd1, 1'b1, 32'h000000F0};
        vecs[7]  = '{1'b1, 5'd10, 2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd1, 1'b1, 2'd3, 1'b1, 32'hFFFF8077};
        vecs[8]  = '{1'b1, 5'd11, 2'd3, 32'hCAFEF00D, 32'h8077F001, 32'h0,        2'd0, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 5'd12, 2'd1, 32'h0,        32'h8077F001, 32'h0,        2'd3, 1'b1, 2'd3, 1'b1, 32'h8077F001};
        vecs[10] = '{1'b1, 5'd0,  2'd0, 32'h0000AAAA, 32'h0,        32'h0,        2'd0, 1'b0, 2'd0, 1'b0, 32'h0000AAAA};
        vecs[11] = '{1'b0, 5'd13, 2'd0, 32'h0000BBBB, 32'h0,        32'h0,        2'd0, 1'b0, 2'd0, 1'b0, 32'h0000BBBB};

        step;
        step;
        @(negedge clk);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_wreg", 32'(writeRegister), 32'd0);
        chk("rst_wdata", writeData, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fwd_hit", 32'(fwd_rs_hit), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step;

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].reg_write, vecs[i].rd, vecs[i].wb_sel, vecs[i].alu, vecs[i].mem,
                   vecs[i].pc4, vecs[i].size, vecs[i].sgn, vecs[i].addr_lo);
            in_valid = 1'b1;
            fwd_rs   = vecs[i].rd;
            fwd_rt   = 5'd0;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("v%0d_nowrite_before", i), 32'(regWrite), 32'd0);
            step;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_wreg", i), 32'(writeRegister), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wdata", i), writeData, vecs[i].exp_data);
            chk($sformatf("v%0d_fwd_hit", i), 32'(fwd_rs_hit), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_fwd_data", i), fwd_rs_data, vecs[i].exp_we ? vecs[i].exp_data : 32'd0);
            chk($sformatf("v%0d_fwd_rt0", i), 32'(fwd_rt_hit), 32'd0);
            step;
            exp_retired++;
            chk($sformatf("v%0d_retired", i), retired, 32'(exp_retired));
        end

        // Backpressure under hold, then ordered release
        wb_hold = 1'b1;
        push_alu(5'd1, 32'h101);
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        step;
        push_alu(5'd2, 32'h202);
        @(negedge clk);
        chk("bp_ready2", 32'(in_ready), 32'd1);
        chk("bp_hold_nowrite", 32'(regWrite), 32'd0);
        step;
        push_alu(5'd3, 32'h303);
        @(negedge clk);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        step;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_nowrite2", 32'(regWrite), 32'd0);
        chk("bp_hold_retired", retired, 32'(exp_retired));
        step;
        wb_hold = 1'b0;
        @(negedge clk);
        chk("bp_d1_we", 32'(regWrite), 32'd1);
        chk("bp_d1_rd", 32'(writeRegister), 32'd1);
        chk("bp_d1_data", writeData, 32'h101);
        step;
        @(negedge clk);
        chk("bp_d2_we", 32'(regWrite), 32'd1);
        chk("bp_d2_rd", 32'(writeRegister), 32'd2);
        chk("bp_d2_data", writeData, 32'h202);
        step;
        exp_retired += 2;
        @(negedge clk);
        chk("bp_empty_we", 32'(regWrite), 32'd0);
        chk("bp_retired", retired, 32'(exp_retired));
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        step;

        // Forwarding priority: two buffered writes to the same register
        wb_hold = 1'b1;
        push_alu(5'd7, 32'h11);
        step;
        push_alu(5'd7, 32'h22);
        step;
        in_valid = 1'b0;
        fwd_rs   = 5'd7;
        fwd_rt   = 5'd8;
        @(negedge clk);
        chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'd1);
        chk("fwd_rs_data", fwd_rs_data, 32'h22);
        chk("fwd_rt_miss", 32'(fwd_rt_hit), 32'd0);
        chk("fwd_rt_data0", fwd_rt_data, 32'd0);
        step;
        fwd_rt = 5'd7;
        @(negedge clk);
        chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'd1);
        chk("fwd_rt_data", fwd_rt_data, 32'h22);
        step;
        wb_hold = 1'b0;
        @(negedge clk);
        chk("fwd_d1_data", writeData, 32'h11);
        chk("fwd_d1_hit_young", fwd_rs_data, 32'h22);
        step;
        @(negedge clk);
        chk("fwd_d2_data", writeData, 32'h22);
        chk("fwd_d2_hit", 32'(fwd_rs_hit), 32'd1);
        step;
        exp_retired += 2;
        chk("fwd_retired", retired, 32'(exp_retired));
        fwd_rs = 5'd0;
        fwd_rt = 5'd0;

        // Reset with two entries buffered
        wb_hold = 1'b1;
        push_alu(5'd14, 32'hAAAA0001);
        step;
        push_alu(5'd15, 32'hAAAA0002);
        step;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step;
        rst_n   = 1'b1;
        wb_hold = 1'b0;
        fwd_rs  = 5'd14;
        @(negedge clk);
        chk("mr_regWrite", 32'(regWrite), 32'd0);
        chk("mr_retired", retired, 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        chk("mr_wdata", writeData, 32'd0);
        chk("mr_fwd_hit", 32'(fwd_rs_hit), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step;
            @(negedge clk);
            chk($sformatf("mr_nowrite%0d", k), 32'(regWrite), 32'd0);
        end
        chk("mr_retired_end", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
